// File: rtl/modacc_pkg.sv
// Shared defaults and FSM state type for the modular frame accumulator.
package modacc_pkg;

    localparam int unsigned DefWidth = 256;
    localparam logic [DefWidth-1:0] DefModulus =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StOut
    } acc_state_e;

endpackage

// File: rtl/mod_add_core.sv
// Combinational (a + b) mod M for operands already reduced below M.
module mod_add_core
    import modacc_pkg::*;
#(
    parameter int unsigned      WIDTH   = DefWidth,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(DefModulus)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic             w_carry;
    logic             w_borrow;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_d;

    assign {w_carry, w_s}  = {1'b0, i_a} + {1'b0, i_b};
    assign {w_borrow, w_d} = {1'b0, w_s} - {1'b0, MODULUS};

    // A carry out means the true sum exceeds 2^WIDTH > M, so the subtraction is always due.
    assign o_sum = (w_carry || !w_borrow) ? w_d : w_s;

endmodule

// File: rtl/modular_acc_256.sv
// Frame accumulator: sums a stream of field elements mod M, one result per in_last frame.
// Define MODACC_REDUCE_IN_EN to accept inputs in [0, 2M) by pre-reducing each beat.
module modular_acc_256
    import modacc_pkg::*;
#(
    parameter int unsigned      WIDTH   = DefWidth,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(DefModulus),
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    acc_state_e       r_state;
    acc_state_e       w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_sum;
    logic             w_accept;

    assign in_ready = (r_state != StOut);
    assign w_accept = in_valid && in_ready;

`ifdef MODACC_REDUCE_IN_EN
    assign w_red = (in_data >= MODULUS) ? (in_data - MODULUS) : in_data;
`else
    assign w_red = in_data;
`endif

    // Feeding 0 in IDLE makes the first beat of a frame load rather than accumulate.
    assign w_add_a = (r_state == StIdle) ? '0 : r_acc;

    mod_add_core #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mod_add_core (
        .i_a   (w_add_a),
        .i_b   (w_red),
        .o_sum (w_sum)
    );

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        if (w_accept) begin
            w_acc_next = w_sum;
            if (r_state == StIdle) begin
                w_cnt_next = CNT_W'(1);
            end else if (r_cnt != '1) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
            w_state_next = in_last ? StOut : StAcc;
        end else if ((r_state == StOut) && out_ready) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign out_valid = (r_state == StOut);
    assign out_data  = out_valid ? r_acc : '0;
    assign out_count = out_valid ? r_cnt : '0;

endmodule
